// File: rtl/isp_cam_capture.sv
// Camera parallel-bus capture: syncs PCLK/VSYNC/HREF/D into clk, assembles
// RGB565 pixels, emits frame strobes and checks frame geometry.
module isp_cam_capture #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        new_frame,
    output logic        data_valid,
    output logic [15:0] pixel_data,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        frame_done,
    output logic        frame_err
);

    localparam logic [9:0] LP_H = 10'(H_PIXELS);
    localparam logic [8:0] LP_V = 9'(V_LINES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_VS,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic       r_vs_s1, r_vs_s2, r_vs_s3;
    logic       r_href_s1, r_href_s2, r_href_s3;
    logic [7:0] r_data_s1, r_data_s2;

    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_phase;
    logic [7:0] r_hi;
    logic       r_err;

    logic       w_pclk_rise;
    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_href_fall;
    logic       w_start;
    logic       w_end;
    logic       w_active;
    logic       w_cap;
    logic       w_lend;
    logic       w_ovf;
    logic       w_lerr;
    logic [8:0] w_y_nx;
    logic [8:0] w_y_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pclk_s1 <= 1'b0;
            r_pclk_s2 <= 1'b0;
            r_pclk_s3 <= 1'b0;
            r_vs_s1   <= 1'b0;
            r_vs_s2   <= 1'b0;
            r_vs_s3   <= 1'b0;
            r_href_s1 <= 1'b0;
            r_href_s2 <= 1'b0;
            r_href_s3 <= 1'b0;
            r_data_s1 <= 8'h00;
            r_data_s2 <= 8'h00;
        end else begin
            r_pclk_s1 <= cam_pclk;
            r_pclk_s2 <= r_pclk_s1;
            r_pclk_s3 <= r_pclk_s2;
            r_vs_s1   <= cam_vsync;
            r_vs_s2   <= r_vs_s1;
            r_vs_s3   <= r_vs_s2;
            r_href_s1 <= cam_href;
            r_href_s2 <= r_href_s1;
            r_href_s3 <= r_href_s2;
            r_data_s1 <= cam_data;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
    assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
    assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;
    assign w_href_fall = ~r_href_s2 & r_href_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_end   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (capture_en) w_next = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (r_vs_s2) w_next = S_VBLANK;
            end
            S_VBLANK: begin
                if (w_vs_fall) begin
                    w_next  = S_ACTIVE;
                    w_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (w_vs_rise) begin
                    w_end  = 1'b1;
                    w_next = capture_en ? S_VBLANK : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_active = (r_state == S_ACTIVE);
    assign w_cap    = w_active & w_pclk_rise & r_href_s2;
    assign w_lend   = w_active & w_href_fall;
    assign w_ovf    = w_cap & r_phase & (r_x >= LP_H);
    assign w_lerr   = w_lend & ((r_x != LP_H) | r_phase);
    assign w_y_nx   = (r_y == 9'h1FF) ? r_y : r_y + 9'd1;
    // A line end coinciding with the frame end must count toward the row total.
    assign w_y_end  = w_lend ? w_y_nx : r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            new_frame  <= 1'b0;
            data_valid <= 1'b0;
            pixel_data <= 16'h0000;
            pixel_x    <= 10'd0;
            pixel_y    <= 9'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            r_x        <= 10'd0;
            r_y        <= 9'd0;
            r_phase    <= 1'b0;
            r_hi       <= 8'h00;
            r_err      <= 1'b0;
        end else begin
            new_frame  <= w_start;
            frame_done <= w_end;
            data_valid <= 1'b0;
            if (w_start) begin
                r_x     <= 10'd0;
                r_y     <= 9'd0;
                r_phase <= 1'b0;
                r_err   <= 1'b0;
            end else if (w_active) begin
                if (w_cap) begin
                    if (!r_phase) begin
                        r_hi    <= r_data_s2;
                        r_phase <= 1'b1;
                    end else begin
                        r_phase <= 1'b0;
                        if (r_x < LP_H) begin
                            data_valid <= 1'b1;
                            pixel_data <= {r_hi, r_data_s2};
                            pixel_x    <= r_x;
                            pixel_y    <= r_y;
                            r_x        <= r_x + 10'd1;
                        end
                    end
                end
                if (w_lend) begin
                    r_x     <= 10'd0;
                    r_phase <= 1'b0;
                    r_y     <= w_y_nx;
                end
                if (w_ovf | w_lerr) r_err <= 1'b1;
                if (w_end) begin
                    frame_err <= r_err | w_ovf | w_lerr
                               | (w_y_end != LP_V);
                end
            end
        end
    end

endmodule

// File: tb/tb_isp_cam_capture.sv
// Bench for isp_cam_capture: camera bus model with pixel/frame scoreboards,
// a table of frame shapes, and hand sequences for enable and reset cases.
module tb_isp_cam_capture;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        capture_en = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        new_frame;
    logic        data_valid;
    logic [15:0] pixel_data;
    logic [9:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic        frame_done;
    logic        frame_err;

    isp_cam_capture #(.H_PIXELS(H), .V_LINES(V)) dut (
        .clk        (clk),
        .reset      (reset),
        .capture_en (capture_en),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .new_frame  (new_frame),
        .data_valid (data_valid),
        .pixel_data (pixel_data),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pix;
        logic [9:0]  x;
        logic [8:0]  y;
    } pix_t;

    typedef struct {
        int   nl;
        int   nb;
        int   dv;
        logic err;
    } vec_t;

    pix_t pq[$];
    logic fq[$];

    int checks = 0;
    int errors = 0;
    int nf_cnt = 0;
    int dv_cnt = 0;
    int fd_cnt = 0;
    logic last_err = 1'b0;
    logic [15:0] first_pix = 16'h0;
    logic [15:0] last_pix = 16'h0;

    logic       m_on = 1'b0;
    int         m_x = 0;
    int         m_y = 0;
    logic       m_err = 1'b0;
    logic       m_phase = 1'b0;
    logic [7:0] m_hi = 8'h00;
    logic [7:0] byte_val = 8'h00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (data_valid) begin
                pix_t e;
                if (dv_cnt == 0) first_pix = pixel_data;
                last_pix = pixel_data;
                dv_cnt++;
                if (pq.size() == 0) begin
                    check("dv_unexpected", 32'(pixel_data), 32'hFFFFFFFF);
                end else begin
                    e = pq.pop_front();
                    check("pix_data", 32'(pixel_data), 32'(e.pix));
                    check("pix_x", 32'(pixel_x), 32'(e.x));
                    check("pix_y", 32'(pixel_y), 32'(e.y));
                end
            end
            if (new_frame) nf_cnt++;
            if (frame_done) begin
                fd_cnt++;
                last_err = frame_err;
                if (fq.size() == 0) begin
                    check("fd_unexpected", 32'(frame_err), 32'hFFFFFFFF);
                end else begin
                    logic fe;
                    fe = fq.pop_front();
                    check("frame_err", 32'(frame_err), 32'(fe));
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte();
        cam_data = byte_val;
        cam_pclk = 1'b0;
        wclk(4);
        cam_pclk = 1'b1;
        if (m_on) begin
            if (!m_phase) begin
                m_hi = byte_val;
                m_phase = 1'b1;
            end else begin
                if (m_x < H) begin
                    pq.push_back('{{m_hi, byte_val}, 10'(m_x), 9'(m_y)});
                    m_x++;
                end else begin
                    m_err = 1'b1;
                end
                m_phase = 1'b0;
            end
        end
        byte_val++;
        wclk(4);
    endtask

    task automatic line_begin();
        cam_href = 1'b1;
        wclk(2);
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        wclk(2);
        cam_href = 1'b0;
        if (m_on) begin
            if (m_x != H || m_phase) m_err = 1'b1;
            m_x = 0;
            m_phase = 1'b0;
            m_y++;
        end
        wclk(6);
    endtask

    task automatic line(input int nb);
        line_begin();
        for (int i = 0; i < nb; i++) send_byte();
        line_end();
    endtask

    task automatic frame_start(input logic cap);
        cam_vsync = 1'b0;
        m_on = cap;
        m_x = 0;
        m_y = 0;
        m_err = 1'b0;
        m_phase = 1'b0;
        wclk(10);
    endtask

    task automatic frame_end();
        wclk(6);
        cam_vsync = 1'b1;
        if (m_on) fq.push_back(m_err || (m_y != V));
        m_on = 1'b0;
        wclk(20);
    endtask

    task automatic check_outs_zero(input string name);
        check(name, 32'({new_frame, data_valid, pixel_data, pixel_x,
                         pixel_y, frame_done, frame_err}), 32'h0);
    endtask

    vec_t tbl[7];
    int nf0, dv0, fd0;

    initial begin
        tbl[0] = '{2, 8, 8, 1'b0};
        tbl[1] = '{2, 7, 6, 1'b1};
        tbl[2] = '{2, 8, 8, 1'b0};
        tbl[3] = '{2, 10, 8, 1'b1};
        tbl[4] = '{3, 8, 12, 1'b1};
        tbl[5] = '{1, 8, 4, 1'b1};
        tbl[6] = '{2, 8, 8, 1'b0};

        wclk(3);
        check_outs_zero("reset_outs");
        capture_en = 1'b1;
        reset = 1'b1;
        wclk(10);

        for (int i = 0; i < 7; i++) begin
            nf0 = nf_cnt;
            dv0 = dv_cnt;
            fd0 = fd_cnt;
            if (i == 0) byte_val = 8'h00;
            frame_start(1'b1);
            for (int l = 0; l < tbl[i].nl; l++) line(tbl[i].nb);
            frame_end();
            check("tbl_nf", 32'(nf_cnt - nf0), 32'd1);
            check("tbl_dv", 32'(dv_cnt - dv0), 32'(tbl[i].dv));
            check("tbl_fd", 32'(fd_cnt - fd0), 32'd1);
            check("tbl_err", 32'(last_err), 32'(tbl[i].err));
            if (i == 0) begin
                check("first_pix", 32'(first_pix), 32'h0001);
                check("last_pix", 32'(last_pix), 32'h0E0F);
            end
        end

        // capture_en dropped mid-frame: frame completes, then idle
        nf0 = nf_cnt; dv0 = dv_cnt; fd0 = fd_cnt;
        frame_start(1'b1);
        line(8);
        capture_en = 1'b0;
        line(8);
        frame_end();
        check("drop_nf", 32'(nf_cnt - nf0), 32'd1);
        check("drop_dv", 32'(dv_cnt - dv0), 32'd8);
        check("drop_fd", 32'(fd_cnt - fd0), 32'd1);
        check("drop_err", 32'(last_err), 32'd0);
        nf0 = nf_cnt; dv0 = dv_cnt; fd0 = fd_cnt;
        frame_start(1'b0);
        line(8);
        line(8);
        frame_end();
        check("idle_nf", 32'(nf_cnt - nf0), 32'd0);
        check("idle_dv", 32'(dv_cnt - dv0), 32'd0);

        // capture_en raised mid-line: waits for the next frame boundary
        nf0 = nf_cnt; dv0 = dv_cnt; fd0 = fd_cnt;
        frame_start(1'b0);
        line_begin();
        for (int i = 0; i < 3; i++) send_byte();
        capture_en = 1'b1;
        for (int i = 0; i < 5; i++) send_byte();
        line_end();
        line(8);
        frame_end();
        check("mid_nf", 32'(nf_cnt - nf0), 32'd0);
        check("mid_dv", 32'(dv_cnt - dv0), 32'd0);
        check("mid_fd", 32'(fd_cnt - fd0), 32'd0);
        frame_start(1'b1);
        line(8);
        line(8);
        frame_end();
        check("mid_next_nf", 32'(nf_cnt - nf0), 32'd1);
        check("mid_next_dv", 32'(dv_cnt - dv0), 32'd8);
        check("mid_next_err", 32'(last_err), 32'd0);

        // reset pulsed mid-line after a bad frame leaves frame_err set
        frame_start(1'b1);
        line(7);
        line(8);
        frame_end();
        check("pre_rst_err", 32'(last_err), 32'd1);
        nf0 = nf_cnt; dv0 = dv_cnt; fd0 = fd_cnt;
        frame_start(1'b1);
        line(8);
        line_begin();
        send_byte();
        send_byte();
        wclk(2);
        reset = 1'b0;
        m_on = 1'b0;
        wclk(3);
        check_outs_zero("mid_rst_outs");
        reset = 1'b1;
        for (int i = 0; i < 6; i++) send_byte();
        line_end();
        frame_end();
        check("rst_nf", 32'(nf_cnt - nf0), 32'd1);
        check("rst_dv", 32'(dv_cnt - dv0), 32'd5);
        check("rst_fd", 32'(fd_cnt - fd0), 32'd0);
        frame_start(1'b1);
        line(8);
        line(8);
        frame_end();
        check("post_rst_nf", 32'(nf_cnt - nf0), 32'd2);
        check("post_rst_dv", 32'(dv_cnt - dv0), 32'd13);
        check("post_rst_fd", 32'(fd_cnt - fd0), 32'd1);
        check("post_rst_err", 32'(last_err), 32'd0);

        check("pq_empty", 32'(pq.size()), 32'd0);
        check("fq_empty", 32'(fq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
